// File: rtl/gelato_split_table_if.sv
// Issue-side command bus and scheduler-side active-path view of the split table.
interface gelato_split_table_if #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_THREADS = 32,
    parameter int unsigned ADDR_WIDTH  = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    logic                   init_valid;
    logic [ADDR_WIDTH-1:0]  init_pc;
    logic                   cmd_valid;
    logic [1:0]             cmd_op;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic [NUM_THREADS-1:0] taken_mask;
    logic [ADDR_WIDTH-1:0]  taken_pc;
    logic [ADDR_WIDTH-1:0]  reconv_pc;
    logic                   cmd_ready;
    logic                   active_valid;
    logic [IDX_W-1:0]       active_idx;
    logic [ADDR_WIDTH-1:0]  active_pc;
    logic [NUM_THREADS-1:0] active_mask;
    logic                   warp_done;
    logic                   overflow;

    modport master (
        output init_valid, init_pc, cmd_valid, cmd_op, next_pc,
               taken_mask, taken_pc, reconv_pc,
        input  cmd_ready, active_valid, active_idx, active_pc,
               active_mask, warp_done, overflow
    );

    modport slave (
        input  init_valid, init_pc, cmd_valid, cmd_op, next_pc,
               taken_mask, taken_pc, reconv_pc,
        output cmd_ready, active_valid, active_idx, active_pc,
               active_mask, warp_done, overflow
    );
endinterface

// File: rtl/gelato_split_table.sv
// Per-warp SIMT divergence/reconvergence table: tracks the single active
// path, allocates two children on a divergent branch and merges finished
// children back into their parent, cascading through shared reconvergence PCs.
module gelato_split_table #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_THREADS = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input logic              clk,
    input logic              rst_n,
    gelato_split_table_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {IDLE, RUN, CASCADE} state_t;
    typedef enum logic [1:0] {OP_ADVANCE, OP_BRANCH, OP_EXIT, OP_RSVD} op_t;

    state_t state, state_nxt;

    logic [NUM_ENTRIES-1:0] ent_valid, ent_active;
    logic [ADDR_WIDTH-1:0]  ent_pc   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  ent_rpc  [NUM_ENTRIES];
    logic [IDX_W-1:0]       ent_par  [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] ent_mask [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] ent_arr  [NUM_ENTRIES];
    logic [IDX_W-1:0]       act_idx;
    logic                   warp_done_q, overflow_q;

    op_t                    op;
    logic [ADDR_WIDTH-1:0]  a_pc, a_rpc;
    logic [IDX_W-1:0]       a_par;
    logic [NUM_THREADS-1:0] a_mask, taken, rc_arr;
    logic                   a_root, rc_full;

    assign op     = op_t'(bus.cmd_op);
    assign a_pc   = ent_pc[act_idx];
    assign a_rpc  = ent_rpc[act_idx];
    assign a_par  = ent_par[act_idx];
    assign a_mask = ent_mask[act_idx];
    assign a_root = (a_par == act_idx);
    assign taken  = bus.taken_mask & a_mask;
    assign rc_arr = ent_arr[a_par] | a_mask;
    assign rc_full = (rc_arr == ent_mask[a_par]);

    // Find the two lowest free entries and the lowest waiting sibling of the active path.
    logic             have_a, have_b, have_s;
    logic [IDX_W-1:0] free_a, free_b, sib;
    always_comb begin
        have_a = 1'b0;
        have_b = 1'b0;
        have_s = 1'b0;
        free_a = '0;
        free_b = '0;
        sib    = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!ent_valid[i]) begin
                if (!have_a) begin
                    have_a = 1'b1;
                    free_a = IDX_W'(i);
                end else if (!have_b) begin
                    have_b = 1'b1;
                    free_b = IDX_W'(i);
                end
            end
            if (!have_s && ent_valid[i] && !ent_active[i] &&
                ent_par[i] == a_par && IDX_W'(i) != a_par) begin
                have_s = 1'b1;
                sib    = IDX_W'(i);
            end
        end
    end

    // Command decode, handshake and next-state selection.
    logic split_need, run_ok, fire, ovf_set, do_reconv, do_setpc, do_split, do_exit;
    logic [ADDR_WIDTH-1:0] set_pc;
    always_comb begin
        split_need = (op == OP_BRANCH) && (taken != '0) && (taken != a_mask);
        run_ok     = (state == RUN) && !bus.init_valid;
        bus.cmd_ready = run_ok && !(split_need && !have_b);
        fire       = bus.cmd_valid && bus.cmd_ready;
        ovf_set    = run_ok && bus.cmd_valid && split_need && !have_b;
        // A path reconverges either by an ADVANCE onto its reconv PC, or during
        // CASCADE when the newly resumed parent already sits on its own reconv PC.
        do_reconv  = !a_root &&
                     ((fire && op == OP_ADVANCE && bus.next_pc == a_rpc) ||
                      (state == CASCADE && !bus.init_valid && a_pc == a_rpc));
        do_setpc   = fire && ((op == OP_ADVANCE && !do_reconv) ||
                              (op == OP_BRANCH && !split_need));
        set_pc     = (op == OP_BRANCH && taken != '0) ? bus.taken_pc : bus.next_pc;
        do_split   = fire && split_need;
        do_exit    = fire && op == OP_EXIT && a_root;

        state_nxt = state;
        if (bus.init_valid)        state_nxt = RUN;
        else if (do_exit)          state_nxt = IDLE;
        else if (do_reconv)        state_nxt = rc_full ? CASCADE : RUN;
        else if (state == CASCADE) state_nxt = RUN;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Table, active index and sticky status updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid   <= '0;
            ent_active  <= '0;
            act_idx     <= '0;
            warp_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                ent_pc[i]   <= '0;
                ent_rpc[i]  <= '0;
                ent_par[i]  <= '0;
                ent_mask[i] <= '0;
                ent_arr[i]  <= '0;
            end
        end else if (bus.init_valid) begin
            ent_valid    <= NUM_ENTRIES'(1);
            ent_active   <= NUM_ENTRIES'(1);
            ent_pc[0]    <= bus.init_pc;
            ent_rpc[0]   <= '1;
            ent_par[0]   <= '0;
            ent_mask[0]  <= '1;
            ent_arr[0]   <= '0;
            act_idx      <= '0;
            warp_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (ovf_set) overflow_q <= 1'b1;
            if (do_setpc) ent_pc[act_idx] <= set_pc;
            if (do_split) begin
                ent_valid[free_a]  <= 1'b1;
                ent_active[free_a] <= 1'b1;
                ent_pc[free_a]     <= bus.taken_pc;
                ent_rpc[free_a]    <= bus.reconv_pc;
                ent_par[free_a]    <= act_idx;
                ent_mask[free_a]   <= taken;
                ent_arr[free_a]    <= '0;
                ent_valid[free_b]  <= 1'b1;
                ent_active[free_b] <= 1'b0;
                ent_pc[free_b]     <= bus.next_pc;
                ent_rpc[free_b]    <= bus.reconv_pc;
                ent_par[free_b]    <= act_idx;
                ent_mask[free_b]   <= a_mask & ~taken;
                ent_arr[free_b]    <= '0;
                ent_active[act_idx] <= 1'b0;
                ent_arr[act_idx]    <= '0;
                ent_pc[act_idx]     <= bus.reconv_pc;
                act_idx             <= free_a;
            end
            if (do_reconv) begin
                ent_valid[act_idx]  <= 1'b0;
                ent_active[act_idx] <= 1'b0;
                ent_arr[a_par]      <= rc_arr;
                if (rc_full) begin
                    ent_active[a_par] <= 1'b1;
                    act_idx           <= a_par;
                end else if (have_s) begin
                    ent_active[sib] <= 1'b1;
                    act_idx         <= sib;
                end
            end
            if (do_exit) begin
                ent_valid[act_idx]  <= 1'b0;
                ent_active[act_idx] <= 1'b0;
                warp_done_q         <= 1'b1;
            end
        end
    end

    assign bus.active_valid = (state == RUN);
    assign bus.active_idx   = act_idx;
    assign bus.active_pc    = a_pc;
    assign bus.active_mask  = a_mask;
    assign bus.warp_done    = warp_done_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: doc/gelato_split_table.md
# gelato_split_table

Parametrised per-warp SIMT divergence/reconvergence table for the Gelato warp scheduler. It holds up to NUM_ENTRIES split entries of NUM_THREADS-wide masks and tracks the single active path of a warp. On divergent branches it allocates children, and when a path reaches its reconvergence PC it merges that path's threads back into the parent. It sits between the issue stage (branch/advance/exit commands) and the warp scheduler (active PC and mask).

## Interface
- NUM_ENTRIES, 8: table depth, ≥3, power of two; IDX_W = $clog2(NUM_ENTRIES)
- NUM_THREADS, 32: threads per warp / mask width
- ADDR_WIDTH, 32: PC width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- init_valid  in  1  launch warp; clears table and loads root
- init_pc  in  ADDR_WIDTH  root start PC
- cmd_valid  in  1  command request from issue
- cmd_op  in  2  0=ADVANCE, 1=BRANCH, 2=EXIT, 3=reserved (ignored, accepted)
- next_pc  in  ADDR_WIDTH  sequential/fall-through PC
- taken_mask  in  NUM_THREADS  per-thread branch outcome (BRANCH only)
- taken_pc  in  ADDR_WIDTH  branch target (BRANCH only)
- reconv_pc  in  ADDR_WIDTH  immediate post-dominator (BRANCH only)
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- active_valid  out  1  an entry is active (state RUN)
- active_idx  out  IDX_W  index of active entry
- active_pc  out  ADDR_WIDTH  current_pc of active entry
- active_mask  out  NUM_THREADS  thread_mask of active entry
- warp_done  out  1  sticky; root exited
- overflow  out  1  sticky; a split was refused for lack of entries

## Operation
- Entry fields: valid, active, current_pc, reconv_pc, reconv_table_num (parent idx), thread_mask, arrived_mask. Root is the entry whose reconv_table_num equals its own index.
- States: IDLE, RUN, CASCADE.
- init_valid (any state, priority over cmd): invalidate all entries, clear warp_done/overflow; entry 0 = {valid, active, init_pc, reconv_pc all-ones, parent 0, mask all-ones, arrived 0}; active_idx=0; go RUN.
- cmd_ready = (state==RUN) & !init_valid & !(BRANCH needing split & free entries < 2).
- ADVANCE: if next_pc == active.reconv_pc and active is not root, then reconverge; else active.current_pc = next_pc.
- BRANCH: t = taken_mask & active.thread_mask. If t==0, current_pc = next_pc. If t==thread_mask, current_pc = taken_pc. Otherwise split: the two lowest-index invalid entries A<B; A = {taken_pc, mask t}, B = {next_pc, mask thread_mask & ~t}; both get reconv_pc from cmd, parent = active idx, arrived 0; parent: active=0, arrived_mask=0, current_pc=reconv_pc; A becomes active. A non-uniform BRANCH with fewer than 2 free entries is not accepted: cmd_ready=0, overflow set.
- Reconverge (child c, parent p): invalidate c; p.arrived_mask |= c.thread_mask. If the new arrived_mask == p.thread_mask, p becomes active, then go CASCADE. Otherwise the lowest-index valid, inactive entry s≠p with parent p becomes active.
- CASCADE (one cycle, cmd_ready=0): if active.current_pc == active.reconv_pc and active is not root, reconverge again (may stay in CASCADE); else return to RUN.
- EXIT: on root, invalidate root, warp_done=1, go IDLE. On a non-root entry, ignored, but the command is accepted.
- Mask arithmetic is bitwise over NUM_THREADS; no PC arithmetic inside the block.

## Timing
- Reset: all entries invalid, state IDLE, active_idx 0, active_valid/warp_done/overflow/cmd_ready 0, active_pc/active_mask 0.
- Accepted command or init takes effect at the next edge; active_* reflect it one cycle later. active_pc/mask are read combinationally from the registered active_idx.
- Each cascade level costs exactly one extra cycle with cmd_ready low.
- cmd_valid is ignored while in IDLE or CASCADE; issue must hold the command until it is accepted.
- Asserting rst_n low mid-operation returns the block to the reset state immediately, regardless of state.

## Test plan
- Reset, then init_pc=0x100 -> next cycle active_valid=1, idx 0, pc 0x100, mask 0xFFFFFFFF; ADVANCE 0x104 -> pc 0x104.
- Uniform BRANCH, taken_mask=0xFFFFFFFF, taken_pc 0x200 -> pc 0x200, no entry allocated; taken_mask=0 -> pc=next_pc.
- Divergent BRANCH, taken 0x0000FFFF, taken_pc 0x200, next 0x108, reconv 0x300 -> active idx 1, mask 0x0000FFFF. ADVANCE to 0x300 -> idx 2, mask 0xFFFF0000, pc 0x108. ADVANCE to 0x300 -> idx 0, pc 0x300, full mask.
- Nested split sharing reconv 0x300 -> after the last inner child arrives, one CASCADE cycle with cmd_ready=0, then root active at 0x300.
- NUM_ENTRIES=4: one split (3 used), then a second divergent BRANCH -> cmd_ready=0, overflow=1. A uniform BRANCH is still accepted.
- EXIT on root -> warp_done=1, active_valid=0. EXIT on a child -> no state change. rst_n pulse mid-split -> all outputs return to 0.
